fifo_1r1w_stream_adapter: RTL and testbench

Downstream companion to fifo_1r1w. It hides the FIFO's 1-cycle read latency and presents a valid/ready stream to the consumer. It issues pops, captures returning read data into a small register skid buffer, and bypasses in-flight data straight to the output. The result is full throughput (one word per cycle) with no combinational path from i_ready to o_fifo_pop.

---
 rtl/fifo_1r1w_stream_adapter.sv | 133 +++++++++++++
 tb/tb_fifo_1r1w_stream_adapter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_1r1w_stream_adapter.sv
// fifo_1r1w_stream_adapter
//   Sits after a fifo_1r1w with a 1-cycle read latency and presents a
//   valid/ready stream. Pops are issued against buffer credit. Returning data
//   is either bypassed straight to the output or parked in a small circular
//   skid buffer. This sustains one word per cycle with no combinational path
//   from i_ready to o_fifo_pop.
//
// Ports
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   o_fifo_pop     : pop request to the FIFO
//   i_fifo_empty   : FIFO empty flag
//   i_fifo_rdata   : FIFO read data, valid the cycle after a pop
//   i_flush        : discard all buffered and in-flight words
//   o_valid/i_ready/o_data : output stream
//   o_occupancy    : words held in the skid buffer (in-flight word excluded)
module fifo_1r1w_stream_adapter #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned SKID_DEPTH = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  output logic                              o_fifo_pop,
  input  logic                              i_fifo_empty,
  input  logic [DWIDTH-1:0]                 i_fifo_rdata,
  input  logic                              i_flush,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [DWIDTH-1:0]                 o_data,
  output logic [$clog2(SKID_DEPTH+1)-1:0]   o_occupancy
);

  localparam int unsigned OCCW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned IDXW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic              r_up;        // low during reset and the first cycle after it
  logic              r_inflight;
  logic [OCCW-1:0]   r_occ;
  logic [IDXW-1:0]   r_head;
  logic [IDXW-1:0]   r_tail;
  logic [DWIDTH-1:0] r_buf [SKID_DEPTH];

  logic              w_occ_nz;
  logic [OCCW:0]     w_pend;
  logic              w_credit;
  logic              w_pop;
  logic              w_valid;
  logic              w_fire;
  logic              w_wr;
  logic              w_rd;
  logic              w_inflight_nxt;
  logic [OCCW-1:0]   w_occ_nxt;
  logic [IDXW-1:0]   w_head_nxt;
  logic [IDXW-1:0]   w_tail_nxt;

  // Circular index increment; wraps by compare so any depth works.
  function automatic logic [IDXW-1:0] f_inc(input logic [IDXW-1:0] idx);
    return (idx == IDXW'(SKID_DEPTH - 1)) ? '0 : idx + IDXW'(1);
  endfunction

  // Pop only against credit: buffered plus in-flight must leave a free slot.
  assign w_occ_nz = (r_occ != '0);
  assign w_pend   = {1'b0, r_occ} + {{OCCW{1'b0}}, r_inflight};
  assign w_credit = (w_pend < (OCCW+1)'(SKID_DEPTH));
  assign w_pop    = i_rst_n & r_up & ~i_fifo_empty & ~i_flush & w_credit;

  // Output select: oldest buffered word, else bypass the arriving word.
  assign w_valid  = i_rst_n & (w_occ_nz | r_inflight);
  assign w_fire   = w_valid & i_ready;
  assign w_wr     = r_inflight & ~(~w_occ_nz & w_fire);
  assign w_rd     = w_occ_nz & w_fire;

  assign o_fifo_pop  = w_pop;
  assign o_valid     = w_valid;
  assign o_data      = w_occ_nz ? r_buf[r_head] : i_fifo_rdata;
  assign o_occupancy = i_rst_n ? r_occ : '0;

  // Next-state computation; flush empties everything and drops the arrival.
  always_comb begin
    w_inflight_nxt = w_pop;
    w_occ_nxt      = r_occ + OCCW'(w_wr) - OCCW'(w_rd);
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    if (w_rd) w_head_nxt = f_inc(r_head);
    if (w_wr) w_tail_nxt = f_inc(r_tail);
    if (i_flush) begin
      w_inflight_nxt = 1'b0;
      w_occ_nxt      = '0;
      w_head_nxt     = '0;
      w_tail_nxt     = '0;
    end
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_up       <= 1'b0;
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_up       <= 1'b1;
      r_inflight <= w_inflight_nxt;
      r_occ      <= w_occ_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
    end
  end

  // Skid storage; contents need no reset since occ gates their use.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && w_wr) r_buf[r_tail] <= i_fifo_rdata;
  end

`ifdef SIMULATION
  logic              r_chk_hold;
  logic [DWIDTH-1:0] r_chk_data;

  // Protocol sanity: legal pops, bounded occupancy, stable output under stall.
  always_ff @(posedge i_clk) begin
    r_chk_hold <= i_rst_n & w_valid & ~i_ready & ~i_flush;
    r_chk_data <= o_data;
    if (i_rst_n) begin
      assert (!(o_fifo_pop && i_fifo_empty)) else $error("pop while fifo empty");
      assert (r_occ <= OCCW'(SKID_DEPTH)) else $error("skid occupancy overflow");
      if (r_chk_hold) begin
        assert (w_valid && (o_data == r_chk_data)) else $error("output changed under backpressure");
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_1r1w_stream_adapter.sv
// Testbench for fifo_1r1w_stream_adapter: emulates the upstream FIFO with a
// queue, keeps a scoreboard of popped-but-undelivered words, and checks the
// stream, pop decisions and occupancy every cycle, plus directed scenarios.
module tb_fifo_1r1w_stream_adapter;

  localparam int unsigned DW = 32;
  localparam int unsigned SD = 2;
  localparam int unsigned OW = $clog2(SD + 1);

  logic          i_clk;
  logic          i_rst_n;
  logic          o_fifo_pop;
  logic          i_fifo_empty;
  logic [DW-1:0] i_fifo_rdata;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [OW-1:0] o_occupancy;

  fifo_1r1w_stream_adapter #(.DWIDTH(DW), .SKID_DEPTH(SD)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_fifo_pop   (o_fifo_pop),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_rdata (i_fifo_rdata),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_occupancy  (o_occupancy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo_q[$];    // upstream FIFO contents
  logic [31:0] exp_q[$];     // scoreboard: popped, not yet delivered
  logic [31:0] got_q[$];     // delivered words
  int          got_cyc[$];   // cycle of each delivery
  int          pop_cnt = 0;
  int          cyc = 0;
  bit          rst_prev = 1'b1;
  bit          last_pop_m = 1'b0;
  logic [31:0] pend_d = '0;  // word the FIFO returns next cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares against the reference model each cycle, then advances it.
  initial begin : monitor
    bit e_pop;
    bit e_valid;
    int e_occ;
    forever begin
      @(negedge i_clk);
      cyc++;
      e_valid = i_rst_n && (exp_q.size() > 0);
      e_pop   = i_rst_n && !rst_prev && !i_fifo_empty && !i_flush && (exp_q.size() < SD);
      e_occ   = !i_rst_n ? 0 : exp_q.size() - (last_pop_m ? 1 : 0);
      chk("pop", 32'(o_fifo_pop), 32'(e_pop));
      chk("valid", 32'(o_valid), 32'(e_valid));
      chk("occupancy", 32'(o_occupancy), 32'(e_occ));
      if (e_valid) chk("data", o_data, exp_q[0]);
      pend_d = $urandom;
      if (!i_rst_n) begin
        exp_q.delete();
        last_pop_m = 1'b0;
      end else begin
        if (o_valid && i_ready) begin
          got_q.push_back(o_data);
          got_cyc.push_back(cyc);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (i_flush) exp_q.delete();
        last_pop_m = o_fifo_pop;
        if (o_fifo_pop) begin
          pop_cnt++;
          if (fifo_q.size() == 0) begin
            chk("pop_from_empty", 32'(1), 32'(0));
          end else begin
            pend_d = fifo_q.pop_front();
            exp_q.push_back(pend_d);
          end
        end
      end
      rst_prev = !i_rst_n;
    end
  end

  // Advance one cycle and present the FIFO's registered outputs.
  task automatic drive(input logic rst_n, input logic rdy, input logic fl);
    @(posedge i_clk);
    #1;
    i_fifo_rdata = pend_d;
    i_fifo_empty = (fifo_q.size() == 0);
    i_rst_n = rst_n;
    i_ready = rdy;
    i_flush = fl;
  endtask

  task automatic clr();
    got_q.delete();
    got_cyc.delete();
    pop_cnt = 0;
  endtask

  task automatic check_log(input string nm, input logic [31:0] exp[$], input bit contig);
    chk({nm, "_count"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      chk({nm, "_data"}, got_q[i], exp[i]);
      if (contig) chk({nm, "_gap"}, 32'(got_cyc[i] - got_cyc[0]), 32'(i));
    end
  endtask

  initial begin : stim
    logic [31:0] e[$];
    bit          flushed;
    i_rst_n = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    i_fifo_rdata = '0;

    // Reset with a non-empty FIFO; no pop until one cycle after release.
    fifo_q.push_back(32'hA5);
    i_fifo_empty = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge i_clk);
    chk("t1_pop_post_rst", 32'(o_fifo_pop), 32'(0));
    chk("t1_valid_post_rst", 32'(o_valid), 32'(0));

    // Single word: one pop, delivered by bypass the next cycle.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    chk("t2_pops", 32'(pop_cnt), 32'(1));
    e = {};
    e.push_back(32'hA5);
    check_log("t2", e, 1'b0);

    // Full-throughput stream 0..7, buffer stays empty.
    clr();
    e = {};
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(32'(i));
      e.push_back(32'(i));
    end
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(negedge i_clk);
      chk("t3_occ", 32'(o_occupancy), 32'(0));
    end
    check_log("t3", e, 1'b1);

    // Backpressure: credit limits pops to two, then drain without bubbles.
    clr();
    e = {};
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(32'(i));
      e.push_back(32'(i));
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("t4_pops", 32'(pop_cnt), 32'(2));
    chk("t4_occ", 32'(o_occupancy), 32'(2));
    chk("t4_data", o_data, 32'(0));
    chk("t4_valid", 32'(o_valid), 32'(1));
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
    check_log("t4", e, 1'b1);

    // Flush while word 4 is in flight: it is dropped, stream resumes at 5.
    clr();
    e = {};
    for (int i = 0; i < 10; i++) begin
      fifo_q.push_back(32'(i));
      if (i != 4) e.push_back(32'(i));
    end
    flushed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk);
      #1;
      i_fifo_rdata = pend_d;
      i_fifo_empty = (fifo_q.size() == 0);
      if (!flushed && last_pop_m && pend_d == 32'd4) begin
        flushed = 1'b1;
        i_flush = 1'b1;
        i_ready = 1'b0;
        @(negedge i_clk);
        drive(1'b1, 1'b1, 1'b0);
        @(negedge i_clk);
        chk("t5_valid_after_flush", 32'(o_valid), 32'(0));
      end else begin
        i_flush = 1'b0;
        i_ready = 1'b1;
      end
    end
    chk("t5_flush_seen", 32'(flushed), 32'(1));
    check_log("t5", e, 1'b0);

    // Mid-stream reset with a full buffer, then a fresh word afterwards.
    clr();
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'(i + 16));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("t6_occ_pre", 32'(o_occupancy), 32'(2));
    fifo_q.delete();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    clr();
    fifo_q.push_back(32'h3C);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge i_clk);
    chk("t6_valid_post_rst", 32'(o_valid), 32'(0));
    chk("t6_occ_post_rst", 32'(o_occupancy), 32'(0));
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    e = {};
    e.push_back(32'h3C);
    check_log("t6", e, 1'b0);

    // Random traffic, backpressure and flushes against the scoreboard.
    for (int i = 0; i < 2000; i++) begin
      if (fifo_q.size() < 6 && ($urandom % 3) == 0) fifo_q.push_back($urandom);
      drive(1'b1, ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
    @(negedge i_clk);
    chk("drain_fifo", 32'(fifo_q.size()), 32'(0));
    chk("drain_scoreboard", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
